sram_controller: RTL and testbench

Memory-stage responder for the load/store commands the control unit issues. It takes the pipeline's 32-bit read and write requests and services them against a 16-bit external SRAM in a fixed multi-cycle sequence. It also drives `ready` low for the whole access so the hazard/freeze logic stalls the pipeline until the access completes.

---
 rtl/sram_controller_pkg.sv | 21 ++
 rtl/sram_addr_map.sv | 41 ++++
 rtl/sram_controller.sv | 209 ++++++++++++++++++++
 tb/tb_sram_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// -----------------------------------------------------------------------------
// sram_controller_pkg
// Shared definitions for the memory-stage SRAM controller:
//   - FSM state encoding (3-bit)
//   - external SRAM geometry (16-bit data, 18-bit half-word address)
// -----------------------------------------------------------------------------
package sram_controller_pkg;

  localparam int SRAM_DW = 16;           // SRAM data bus width
  localparam int SRAM_AW = 18;           // SRAM half-word address width
  localparam int WORD_AW = SRAM_AW - 1;  // 32-bit word index width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/sram_addr_map.sv
// -----------------------------------------------------------------------------
// sram_addr_map
// Combinational translation of a pipeline byte address into a 32-bit word
// index of the external SRAM. Word 0 lives at byte address BASE_ADDR.
//
// Optional build macro: SRAM_ADDR_CHECK_EN adds the range_err output.
//
// Ports:
//   address    in  [31:0]        byte address from the ALU
//   word       out [WORD_AW-1:0] word index, wraps modulo 2^WORD_AW
//   range_err  out               (SRAM_ADDR_CHECK_EN only) address below the
//                                base or beyond the last SRAM word
// -----------------------------------------------------------------------------
module sram_addr_map
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic [31:0]        address,
  output logic [WORD_AW-1:0] word
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic               range_err
`endif
);

  logic [31:0] offset;

  assign offset = address - BASE_ADDR;

  // Dropping the upper bits gives the modulo-2^17 wrap of the unchecked build.
  assign word = WORD_AW'(offset >> 2);

`ifdef SRAM_ADDR_CHECK_EN
  // Below the base the subtraction wraps to a huge offset, but the explicit
  // compare keeps the intent readable.
  assign range_err = (address < BASE_ADDR) ||
                     ((offset >> 2) > 32'((1 << WORD_AW) - 1));
`endif

endmodule

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// Memory-stage responder: services 32-bit loads/stores against a 16-bit
// external SRAM as two half-word accesses (LOW then HIGH) followed by
// WAIT_CYCLES settle cycles and a one-cycle DONE. ready stays low for the
// whole access so the pipeline freezes.
//
// Optional build macro: SRAM_ADDR_CHECK_EN adds the addr_err output and
// sends out-of-range requests straight to DONE without touching the SRAM.
//
// Parameters:
//   WAIT_CYCLES  settle cycles after the HIGH access (0..15)
//   BASE_ADDR    byte address mapped to SRAM word 0
//
// Ports:
//   clk        in      clock, rising edge
//   rst        in      asynchronous reset, active-low
//   wr_en      in      store request
//   rd_en      in      load request (ignored when wr_en is also set)
//   address    in  32  byte address
//   wdata      in  32  store data
//   rdata      out 32  load result, held between loads
//   ready      out     0 = freeze pipeline
//   addr_err   out     (SRAM_ADDR_CHECK_EN only) high in DONE of a rejected request
//   sram_dq    inout16 SRAM data bus, driven only while writing
//   sram_addr  out 18  SRAM half-word address
//   sram_we_n  out     SRAM write strobe, active-low
// -----------------------------------------------------------------------------
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
`ifdef SRAM_ADDR_CHECK_EN
  output logic               addr_err,
`endif
  inout  wire  [SRAM_DW-1:0] sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n
);

  state_t state_reg, state_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic               is_write_reg, is_write_next;
  logic [WORD_AW-1:0] word_reg, word_next;
  logic [15:0]        wdata_hi_reg, wdata_hi_next;  // low half goes straight to the bus
  logic [31:0]        rdata_reg, rdata_next;
  logic [SRAM_AW-1:0] sram_addr_reg, sram_addr_next;
  logic               we_n_reg, we_n_next;
  logic               dq_oe_reg, dq_oe_next;
  logic [SRAM_DW-1:0] dq_out_reg, dq_out_next;
  logic               addr_err_reg, addr_err_next;

  logic [WORD_AW-1:0] map_word;
  logic               map_err;
  logic               req;

  assign req = wr_en | rd_en;

`ifdef SRAM_ADDR_CHECK_EN
  sram_addr_map #(
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_map (
    .address   (address),
    .word      (map_word),
    .range_err (map_err)
  );
`else
  sram_addr_map #(
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_map (
    .address (address),
    .word    (map_word)
  );
  assign map_err = 1'b0;
`endif

  // State register and all registered outputs. The SRAM strobe, address and
  // write data are registered so they are glitch-free and stable for the
  // entire LOW/HIGH cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      is_write_reg  <= 1'b0;
      word_reg      <= '0;
      wdata_hi_reg  <= '0;
      rdata_reg     <= '0;
      sram_addr_reg <= '0;
      we_n_reg      <= 1'b1;
      dq_oe_reg     <= 1'b0;
      dq_out_reg    <= '0;
      addr_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      is_write_reg  <= is_write_next;
      word_reg      <= word_next;
      wdata_hi_reg  <= wdata_hi_next;
      rdata_reg     <= rdata_next;
      sram_addr_reg <= sram_addr_next;
      we_n_reg      <= we_n_next;
      dq_oe_reg     <= dq_oe_next;
      dq_out_reg    <= dq_out_next;
      addr_err_reg  <= addr_err_next;
    end
  end

  // Next-state logic. Bus values computed here are those for the state being
  // entered, because they land in registers on the same edge.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    is_write_next  = is_write_reg;
    word_next      = word_reg;
    wdata_hi_next  = wdata_hi_reg;
    rdata_next     = rdata_reg;
    sram_addr_next = sram_addr_reg;
    we_n_next      = 1'b1;
    dq_oe_next     = 1'b0;
    dq_out_next    = dq_out_reg;
    addr_err_next  = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (req) begin
          is_write_next = wr_en;  // write wins when both are set
          word_next     = map_word;
          wdata_hi_next = wdata[31:16];
          if (map_err) begin
            state_next    = ST_DONE;
            addr_err_next = 1'b1;
          end else begin
            state_next     = ST_LOW;
            sram_addr_next = {map_word, 1'b0};
            we_n_next      = ~wr_en;
            dq_oe_next     = wr_en;
            dq_out_next    = wdata[15:0];
          end
        end
      end

      ST_LOW: begin
        if (!is_write_reg) begin
          rdata_next[15:0] = sram_dq;
        end
        state_next     = ST_HIGH;
        sram_addr_next = {word_reg, 1'b1};
        we_n_next      = ~is_write_reg;
        dq_oe_next     = is_write_reg;
        dq_out_next    = wdata_hi_reg;
      end

      ST_HIGH: begin
        if (!is_write_reg) begin
          rdata_next[31:16] = sram_dq;
        end
        cnt_next = '0;
        if (WAIT_CYCLES == 0) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_reg == 4'(WAIT_CYCLES - 1)) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Combinational so the freeze is seen in the same cycle the request appears.
  assign ready = ((state_reg == ST_IDLE) && !req) || (state_reg == ST_DONE);

  assign rdata     = rdata_reg;
  assign sram_addr = sram_addr_reg;
  assign sram_we_n = we_n_reg;
  assign sram_dq   = dq_oe_reg ? dq_out_reg : {SRAM_DW{1'bz}};

`ifdef SRAM_ADDR_CHECK_EN
  assign addr_err = addr_err_reg;
`else
  // Only the checked build can reach DONE with an error flagged.
  logic unused_addr_err;
  assign unused_addr_err = addr_err_reg;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
// Self-checking bench for sram_controller with a behavioural SRAM and a
// word-level reference model (associative array of 32-bit words).
// -----------------------------------------------------------------------------
module tb_sram_controller;

  localparam int          W    = 4;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
`ifdef SRAM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  sram_controller #(
    .WAIT_CYCLES (W),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
`ifdef SRAM_ADDR_CHECK_EN
    .addr_err  (addr_err),
`endif
    .sram_dq   (sram_dq),
    .sram_addr (sram_addr),
    .sram_we_n (sram_we_n)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: drives the bus whenever it is not being written.
  // probe_mode replaces the memory contents with a fixed pattern, used to
  // confirm the controller has released the bus.
  logic [15:0] sram_mem [0:262143];
  bit          tb_drive_en = 1'b0;
  bit          probe_mode  = 1'b0;

  assign sram_dq = (tb_drive_en && sram_we_n) ?
                   (probe_mode ? 16'hA5C3 : sram_mem[sram_addr]) : 16'hzzzz;

  always @(posedge clk) begin
    if (sram_we_n == 1'b0) sram_mem[sram_addr] <= sram_dq;
  end

  // Reference model: 32-bit words by word index, plus the load result.
  logic [31:0] ref_words [int];
  logic [31:0] ref_rdata = '0;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One pipeline access: request is held until ready returns, as the frozen
  // pipeline would, then dropped in the DONE cycle.
  task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] data);
    logic [31:0] offset;
    logic [31:0] widx;
    logic [16:0] w17;
    logic [17:0] st_addr [2];
    logic [15:0] st_data [2];
    bit          err;
    int          exp_stall;
    int          exp_n;
    int          stall;
    int          n;
    int          key;

    offset = addr - BASE;
    widx   = offset >> 2;
    w17    = widx[16:0];
    key    = int'(w17);
    err    = 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
    err = (addr < BASE) || (widx > 32'h1FFFF);
`endif
    exp_stall = err ? 1 : W + 3;
    exp_n     = (wr && !err) ? 2 : 0;

    @(negedge clk);
    wr_en   = wr;
    rd_en   = rd;
    address = addr;
    wdata   = data;
    #1;
    stall = 0;
    n     = 0;
    while (!ready && stall < 64) begin
      stall++;
      if (sram_we_n == 1'b0) begin
        if (n < 2) begin
          st_addr[n] = sram_addr;
          st_data[n] = sram_dq;
        end
        n++;
      end
      @(negedge clk);
    end

    if (!err) begin
      if (wr) begin
        ref_words[key] = data;
      end else if (rd) begin
        ref_rdata = ref_words.exists(key) ? ref_words[key] : 32'h0;
      end
    end

    check_eq("stall", 32'(stall), 32'(exp_stall));
    check_eq("rdata_done", rdata, ref_rdata);
`ifdef SRAM_ADDR_CHECK_EN
    check_eq("addr_err", 32'(addr_err), 32'(err));
`endif
    check_eq("strobes", 32'(n), 32'(exp_n));
    if (n == 2 && exp_n == 2) begin
      check_eq("lo_addr", 32'(st_addr[0]), 32'({w17, 1'b0}));
      check_eq("lo_data", 32'(st_data[0]), 32'(data[15:0]));
      check_eq("hi_addr", 32'(st_addr[1]), 32'({w17, 1'b1}));
      check_eq("hi_data", 32'(st_data[1]), 32'(data[31:16]));
    end
    $display("txn %0d: wr=%0b rd=%0b addr=%h wdata=%h rdata=%h stall=%0d strobes=%0d err=%0b",
             txn, wr, rd, addr, data, rdata, stall, n, err);
    txn++;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle_cycles(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_eq("idle_ready", 32'(ready), 32'd1);
      check_eq("idle_rdata", rdata, ref_rdata);
      check_eq("idle_we_n", 32'(sram_we_n), 32'd1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] tmp;
    logic [31:0] a;
    int          kind;

    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;

    // Reset with no request pending.
    tb_drive_en = 1'b1;
    probe_mode  = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_we_n", 32'(sram_we_n), 32'd1);
    check_eq("rst_addr", 32'(sram_addr), 32'h0);
    check_eq("rst_bus_free", 32'(sram_dq), 32'h0000A5C3);
    rst        = 1'b1;
    probe_mode = 1'b0;

    // Directed store and load at 1028 (word 1).
    do_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 32'd1028, 32'h0);
    check_eq("load_1028", rdata, 32'hDEADBEEF);
    idle_cycles(2);

    // Write wins over read; rdata must not move.
    do_access(1'b1, 1'b1, 32'd1100, 32'hCAFEF00D);
    check_eq("both_rdata", rdata, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 32'd1100, 32'h0);

    // Reset in the HIGH cycle of a store.
    tb_drive_en = 1'b0;
    @(negedge clk);
    wr_en   = 1'b1;
    address = 32'd1028;
    wdata   = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("mid_high_we_n", 32'(sram_we_n), 32'd0);
    check_eq("mid_high_addr", 32'(sram_addr), 32'd3);
    rst   = 1'b0;
    wr_en = 1'b0;
    #1;
    tb_drive_en = 1'b1;
    probe_mode  = 1'b1;
    #1;
    check_eq("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    check_eq("mid_rst_bus_free", 32'(sram_dq), 32'h0000A5C3);
    check_eq("mid_rst_ready", 32'(ready), 32'd1);
    check_eq("mid_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst        = 1'b1;
    probe_mode = 1'b0;
    ref_rdata  = 32'h0;
    tmp        = ref_words[1];
    ref_words[1] = {tmp[31:16], 16'h5678};
    do_access(1'b0, 1'b1, 32'd1028, 32'h0);
    check_eq("partial_word", rdata, 32'hDEAD5678);

`ifdef SRAM_ADDR_CHECK_EN
    // Below the base: rejected without touching the SRAM.
    do_access(1'b0, 1'b1, 32'd512, 32'h0);
`endif

    // Randomized mix of loads, stores and write-wins requests.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      a    = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'h00080000;        // one SRAM span up
      if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(0, 1023));
      do_access(kind != 1, kind != 0, a, $urandom);
      idle_cycles($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
